// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and
// default sizes used by the arbiter and its round-robin picker.
package dmem_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_MAX_BURST = 4;

    // Owner of the memory port during the previous cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A locked owner keeps the grant while it
// still has burst room; otherwise ties go to the port that did not win last.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic   a_req,
    input  logic   b_req,
    input  logic   a_lock,
    input  logic   b_lock,
    input  owner_t owner,
    input  owner_t last_owner,
    input  logic   burst_room,
    output logic   gnt_a,
    output logic   gnt_b
);

    // Combinational grant decision; at most one grant, only with a request.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (a_req && !b_req) begin
            gnt_a = 1'b1;
        end else if (b_req && !a_req) begin
            gnt_b = 1'b1;
        end else if (a_req && b_req) begin
            if (owner == OWN_A && a_lock && burst_room) begin
                gnt_a = 1'b1;
            end else if (owner == OWN_B && b_lock && burst_room) begin
                gnt_b = 1'b1;
            end else if (last_owner == OWN_A) begin
                gnt_b = 1'b1;
            end else begin
                gnt_a = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between port A (CPU) and port B
// (DMA/debug). One access per cycle, responses registered one cycle later.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              SYS_clk,
    input  logic              SYS_rst_n,

    input  logic              A_req,
    input  logic              A_we,
    input  logic              A_lock,
    input  logic [ADDR_W-1:0] A_addr,
    input  logic [DATA_W-1:0] A_wdata,
    output logic              A_gnt,
    output logic              A_rvalid,
    output logic [DATA_W-1:0] A_rdata,
    output logic              A_err,

    input  logic              B_req,
    input  logic              B_we,
    input  logic              B_lock,
    input  logic [ADDR_W-1:0] B_addr,
    input  logic [DATA_W-1:0] B_wdata,
    output logic              B_gnt,
    output logic              B_rvalid,
    output logic [DATA_W-1:0] B_rdata,
    output logic              B_err,

    output logic [ADDR_W-1:0] DMEM_address,
    output logic [DATA_W-1:0] DMEM_data_in,
    output logic              DMEM_mem_write,
    output logic              DMEM_mem_read,
    input  logic [DATA_W-1:0] DMEM_data_out
);

    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(MEM_DEPTH);

    owner_t           owner;
    owner_t           last_owner;
    logic [CNT_W-1:0] burst_cnt;

    logic a_oor;
    logic b_oor;
    logic burst_room;
    logic same_locked;

    assign a_oor      = (A_addr >= DEPTH_LIM);
    assign b_oor      = (B_addr >= DEPTH_LIM);
    assign burst_room = (burst_cnt < BURST_MAX);

    rr_arb2 u_rr_arb2 (
        .a_req      (A_req),
        .b_req      (B_req),
        .a_lock     (A_lock),
        .b_lock     (B_lock),
        .owner      (owner),
        .last_owner (last_owner),
        .burst_room (burst_room),
        .gnt_a      (A_gnt),
        .gnt_b      (B_gnt)
    );

    // Repeat grant to a locked owner extends the current burst.
    assign same_locked = (A_gnt && owner == OWN_A && A_lock) ||
                         (B_gnt && owner == OWN_B && B_lock);

    // Memory-side mux; out-of-range accesses are granted but never reach memory.
    always_comb begin
        DMEM_address   = '0;
        DMEM_data_in   = '0;
        DMEM_mem_write = 1'b0;
        DMEM_mem_read  = 1'b0;
        if (A_gnt) begin
            DMEM_address   = A_addr;
            DMEM_data_in   = A_wdata;
            DMEM_mem_write = A_we && !a_oor;
            DMEM_mem_read  = !A_we && !a_oor;
        end else if (B_gnt) begin
            DMEM_address   = B_addr;
            DMEM_data_in   = B_wdata;
            DMEM_mem_write = B_we && !b_oor;
            DMEM_mem_read  = !B_we && !b_oor;
        end
    end

    // Owner FSM, burst counter and registered responses.
    always_ff @(posedge SYS_clk) begin
        if (!SYS_rst_n) begin
            owner      <= IDLE;
            last_owner <= OWN_B;
            burst_cnt  <= '0;
            A_rvalid   <= 1'b0;
            A_rdata    <= '0;
            A_err      <= 1'b0;
            B_rvalid   <= 1'b0;
            B_rdata    <= '0;
            B_err      <= 1'b0;
        end else begin
            if (A_gnt) begin
                owner      <= OWN_A;
                last_owner <= OWN_A;
            end else if (B_gnt) begin
                owner      <= OWN_B;
                last_owner <= OWN_B;
            end else begin
                owner      <= IDLE;
            end

            if (same_locked) begin
                if (burst_cnt < BURST_MAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else if (A_gnt || B_gnt) begin
                burst_cnt <= CNT_W'(1);
            end else begin
                burst_cnt <= '0;
            end

            A_rvalid <= A_gnt;
            A_err    <= A_gnt && a_oor;
            A_rdata  <= (A_gnt && !A_we && !a_oor) ? DMEM_data_out : '0;
            B_rvalid <= B_gnt;
            B_err    <= B_gnt && b_oor;
            B_rdata  <= (B_gnt && !B_we && !b_oor) ? DMEM_data_out : '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word memory.
module tb_dmem_arbiter;

    logic        SYS_clk = 1'b0;
    logic        SYS_rst_n;
    logic        A_req, A_we, A_lock;
    logic [31:0] A_addr, A_wdata;
    logic        A_gnt, A_rvalid, A_err;
    logic [31:0] A_rdata;
    logic        B_req, B_we, B_lock;
    logic [31:0] B_addr, B_wdata;
    logic        B_gnt, B_rvalid, B_err;
    logic [31:0] B_rdata;
    logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
    logic        DMEM_mem_write, DMEM_mem_read;

    logic [31:0] mem [256];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 SYS_clk = ~SYS_clk;

    dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_DEPTH (256),
        .MAX_BURST (4)
    ) dut (
        .SYS_clk        (SYS_clk),
        .SYS_rst_n      (SYS_rst_n),
        .A_req          (A_req),
        .A_we           (A_we),
        .A_lock         (A_lock),
        .A_addr         (A_addr),
        .A_wdata        (A_wdata),
        .A_gnt          (A_gnt),
        .A_rvalid       (A_rvalid),
        .A_rdata        (A_rdata),
        .A_err          (A_err),
        .B_req          (B_req),
        .B_we           (B_we),
        .B_lock         (B_lock),
        .B_addr         (B_addr),
        .B_wdata        (B_wdata),
        .B_gnt          (B_gnt),
        .B_rvalid       (B_rvalid),
        .B_rdata        (B_rdata),
        .B_err          (B_err),
        .DMEM_address   (DMEM_address),
        .DMEM_data_in   (DMEM_data_in),
        .DMEM_mem_write (DMEM_mem_write),
        .DMEM_mem_read  (DMEM_mem_read),
        .DMEM_data_out  (DMEM_data_out)
    );

    // Behavioural single-port memory: combinational read, write on edge.
    assign DMEM_data_out = mem[DMEM_address[7:0]];
    always @(posedge SYS_clk) begin
        if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_mem(input string tag);
        check_val({tag, " addr"}, DMEM_address, 32'h0);
        check_val({tag, " din"},  DMEM_data_in, 32'h0);
        check_val({tag, " wr"},   {31'h0, DMEM_mem_write}, 32'h0);
        check_val({tag, " rd"},   {31'h0, DMEM_mem_read}, 32'h0);
    endtask

    task automatic next_cycle;
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic mid_cycle;
        @(negedge SYS_clk);
    endtask

    logic exp_a_lock [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        SYS_rst_n = 1'b0;
        A_req = 0; A_we = 0; A_lock = 0; A_addr = 0; A_wdata = 0;
        B_req = 0; B_we = 0; B_lock = 0; B_addr = 0; B_wdata = 0;

        // Reset state
        next_cycle;
        next_cycle;
        mid_cycle;
        check_val("rst A_rvalid", {31'h0, A_rvalid}, 32'h0);
        check_val("rst B_rvalid", {31'h0, B_rvalid}, 32'h0);
        check_val("rst A_rdata", A_rdata, 32'h0);
        check_val("rst B_rdata", B_rdata, 32'h0);
        check_val("rst errs", {30'h0, A_err, B_err}, 32'h0);
        check_idle_mem("rst");

        // A write 5 then A read 5
        next_cycle;
        SYS_rst_n = 1'b1;
        A_req = 1; A_we = 1; A_addr = 5; A_wdata = 32'hDEADBEEF;
        mid_cycle;
        check_val("wr gnt", {30'h0, A_gnt, B_gnt}, 32'h2);
        check_val("wr mem_write", {31'h0, DMEM_mem_write}, 32'h1);
        check_val("wr mem_read", {31'h0, DMEM_mem_read}, 32'h0);
        check_val("wr address", DMEM_address, 32'd5);
        check_val("wr data_in", DMEM_data_in, 32'hDEADBEEF);
        next_cycle;
        A_we = 0;
        mid_cycle;
        check_val("rd gnt", {30'h0, A_gnt, B_gnt}, 32'h2);
        check_val("rd mem_read", {31'h0, DMEM_mem_read}, 32'h1);
        check_val("rd mem_write", {31'h0, DMEM_mem_write}, 32'h0);
        check_val("wr ack rvalid", {31'h0, A_rvalid}, 32'h1);
        check_val("wr ack rdata", A_rdata, 32'h0);
        next_cycle;
        A_req = 0;
        mid_cycle;
        check_val("rd rvalid", {31'h0, A_rvalid}, 32'h1);
        check_val("rd rdata", A_rdata, 32'hDEADBEEF);
        check_val("rd err", {31'h0, A_err}, 32'h0);
        check_val("idle gnt", {30'h0, A_gnt, B_gnt}, 32'h0);
        check_idle_mem("idle");

        // Reset, then both request without lock: A,B,A,B
        next_cycle;
        SYS_rst_n = 1'b0;
        next_cycle;
        SYS_rst_n = 1'b1;
        A_req = 1; A_we = 0; A_addr = 5;
        B_req = 1; B_we = 0; B_addr = 5;
        for (int i = 0; i < 4; i++) begin
            mid_cycle;
            check_val($sformatf("rr gnt %0d", i), {30'h0, A_gnt, B_gnt},
                      (i % 2 == 0) ? 32'h2 : 32'h1);
            if (i > 0) begin
                check_val($sformatf("rr rvalid %0d", i), {30'h0, A_rvalid, B_rvalid},
                          (i % 2 == 1) ? 32'h2 : 32'h1);
                check_val($sformatf("rr rdata %0d", i), (i % 2 == 1) ? A_rdata : B_rdata,
                          32'hDEADBEEF);
            end
            next_cycle;
        end
        A_req = 0; B_req = 0;
        mid_cycle;
        check_val("rr last B rvalid", {30'h0, A_rvalid, B_rvalid}, 32'h1);
        check_val("rr B rdata", B_rdata, 32'hDEADBEEF);

        // Locked burst by A, limit 4
        next_cycle;
        A_req = 1; B_req = 1; A_lock = 1;
        for (int i = 0; i < 6; i++) begin
            mid_cycle;
            check_val($sformatf("burst gnt %0d", i), {30'h0, A_gnt, B_gnt},
                      exp_a_lock[i] ? 32'h2 : 32'h1);
            next_cycle;
        end
        A_req = 0; B_req = 0; A_lock = 0;
        mid_cycle;

        // B out-of-range read and write
        next_cycle;
        B_req = 1; B_we = 0; B_addr = 300;
        mid_cycle;
        check_val("oor gnt", {30'h0, A_gnt, B_gnt}, 32'h1);
        check_val("oor rd mem_read", {31'h0, DMEM_mem_read}, 32'h0);
        check_val("oor rd mem_write", {31'h0, DMEM_mem_write}, 32'h0);
        next_cycle;
        B_we = 1; B_wdata = 32'h12345678;
        mid_cycle;
        check_val("oor rd rvalid", {31'h0, B_rvalid}, 32'h1);
        check_val("oor rd err", {31'h0, B_err}, 32'h1);
        check_val("oor rd rdata", B_rdata, 32'h0);
        check_val("oor wr mem_write", {31'h0, DMEM_mem_write}, 32'h0);
        next_cycle;
        B_req = 0; B_we = 0;
        mid_cycle;
        check_val("oor wr err", {30'h0, B_rvalid, B_err}, 32'h3);
        check_val("oor mem[44]", mem[44], 32'h0);
        check_val("oor mem[5]", mem[5], 32'hDEADBEEF);

        // Reset lands on the edge capturing an A read response
        next_cycle;
        A_req = 1; A_we = 0; A_addr = 5;
        mid_cycle;
        check_val("rstfl gnt", {30'h0, A_gnt, B_gnt}, 32'h2);
        SYS_rst_n = 1'b0;
        A_req = 0;
        next_cycle;
        mid_cycle;
        check_val("rstfl A_rvalid", {31'h0, A_rvalid}, 32'h0);
        check_val("rstfl A_rdata", A_rdata, 32'h0);
        check_idle_mem("rstfl");
        next_cycle;
        SYS_rst_n = 1'b1;
        A_req = 1; B_req = 1;
        mid_cycle;
        check_val("rstfl tie gnt", {30'h0, A_gnt, B_gnt}, 32'h2);

        // Three idle cycles keep last_owner=A, so the next tie goes to B
        next_cycle;
        A_req = 0; B_req = 0;
        for (int i = 0; i < 3; i++) begin
            mid_cycle;
            check_val($sformatf("idle3 gnt %0d", i), {30'h0, A_gnt, B_gnt}, 32'h0);
            check_val($sformatf("idle3 rvalid %0d", i), {30'h0, A_rvalid, B_rvalid},
                      (i == 0) ? 32'h2 : 32'h0);
            check_idle_mem($sformatf("idle3 %0d", i));
            next_cycle;
        end
        A_req = 1; B_req = 1;
        mid_cycle;
        check_val("idle3 tie gnt", {30'h0, A_gnt, B_gnt}, 32'h1);

        // Saturated burst with B idle, then B joins and wins at once
        next_cycle;
        B_req = 0; A_lock = 1;
        for (int i = 0; i < 6; i++) begin
            mid_cycle;
            check_val($sformatf("sat gnt %0d", i), {30'h0, A_gnt, B_gnt}, 32'h2);
            next_cycle;
        end
        B_req = 1;
        mid_cycle;
        check_val("sat B joins", {30'h0, A_gnt, B_gnt}, 32'h1);
        next_cycle;
        A_req = 0; B_req = 0; A_lock = 0;
        next_cycle;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
